lcd_spi_rx: RTL and testbench
=============================

LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2): received-byte FIFO entries.
REQ-002 SHALL have ports, in this order:
  clk  in  1  system clock; must be >=4x sck frequency.
  rst_n  in  1  reset; asynchronous, active-low.
  ena  in  1  receiver enable; 0 ignores all sck edges.
  sck  in  1  SPI clock, mode 0, asynchronous to clk.
  mosi  in  1  serial data, MSB first.
  cs  in  1  chip select, active-low.
  dc  in  1  0 = command byte, 1 = data byte.
  rx_ready  in  1  consumer accepts the head byte.
  rx_valid  out  1  FIFO not empty.
  rx_byte  out  8  head byte.
  rx_dc  out  1  dc flag of the head byte.
  cur_cmd  out  8  last command byte received.
  pix_valid  out  1  one-cycle pulse: pixel completed.
  pix_data  out  16  RGB565 pixel, first byte in [15:8].
  pix_x  out  16  column of pix_data.
  pix_y  out  16  row of pix_data.
  overflow  out  1  sticky: byte dropped because FIFO full.
  frame_err  out  1  sticky: cs rose mid-byte.

Function
REQ-003 SHALL pass sck, mosi, cs and dc through 2-flop synchronizers, then detect the sck rising edge from the synchronized value.
REQ-004 SHALL, on each detected sck rise with synced cs=0 and ena=1, shift mosi into an 8-bit register and increment a 3-bit bit counter.
REQ-005 SHALL, on the 8th bit, form a byte with dc sampled at that edge, push it, and reset the bit counter to 0.
REQ-006 SHALL hold the bit counter and shift register at 0 while synced cs=1.
REQ-007 SHALL, when cs rises with a nonzero bit counter, discard the partial byte and set frame_err.
REQ-008 SHALL assert rx_valid no later than 4 clk cycles after the sck pin edge carrying bit 0 of a byte.
REQ-009 SHALL pop the FIFO on any cycle with rx_valid=1 and rx_ready=1; rx_byte and rx_dc are stable while rx_valid=1 and rx_ready=0.
REQ-010 SHALL drop a push that arrives while the FIFO is full and set overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-011 SHALL run the command tracker on pushed bytes, independent of rx_ready.
REQ-012 SHALL, on a dc=0 byte: set cur_cmd to the byte, clear the 8-bit parameter index (which saturates at 255), and clear the pixel phase.
REQ-013 SHALL, when cur_cmd=0x2A (CASET), load parameters 0..3 into col_start[15:8], col_start[7:0], col_end[15:8], col_end[7:0]; later parameters are ignored.
REQ-014 SHALL, when cur_cmd=0x2B (PASET), load row_start and row_end in the same way.
REQ-015 SHALL, on command 0x2C (RAMWR), set the write pointer to (col_start, row_start).
REQ-016 SHALL, for dc=1 bytes under RAMWR, latch the even-phase byte as the high byte; each odd-phase byte completes a pixel.
REQ-017 SHALL, on each completed pixel, pulse pix_valid for 1 cycle with pix_data, pix_x and pix_y equal to the current pointer.
REQ-018 SHALL advance the pointer after each pixel as follows:
  - x < col_end: x+1.
  - x >= col_end: x = col_start, then y+1.
  - y >= row_end: y = row_start.
REQ-019 SHALL produce no pixels for data bytes under any other command.

Reset
REQ-020 SHALL, while rst_n=0 (asynchronous), clear all of the following: synchronizers, shift register, bit counter, FIFO pointers, cur_cmd, parameter index, pixel phase, pointer, pix_data, rx_valid, pix_valid, overflow, frame_err.
REQ-021 SHALL reset col_start/col_end to 0/239 and row_start/row_end to 0/319.
REQ-022 SHALL treat reset asserted mid-byte as a full reset; no partial byte is pushed after release.

Structure
REQ-023 SHALL take the following from shared package lcd_spi_pkg:
  - CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C;
  - default window constants COL_END_DEF=239 and ROW_END_DEF=319.
REQ-024 SHALL implement the FIFO as sub-module lcd_rx_fifo: 9-bit width, parameterized depth, full/empty flags, simultaneous push/pop.

Verification
REQ-025 SHALL verify: after reset, rx_valid, pix_valid, overflow and frame_err are 0, cur_cmd=0, and the window is 0..239/0..319.
REQ-026 SHALL verify: cmd 0x2A then data 00 0A 00 0B -> FIFO yields (2A,0),(00,1),(0A,1),(00,1),(0B,1); col_start=10, col_end=11.
REQ-027 SHALL verify: CASET 10..11, PASET 5..6, RAMWR, then F8 00 sent five times -> five pix_valid pulses, each F800, at (10,5),(11,5),(10,6),(11,6),(10,5).
REQ-028 SHALL verify: FIFO_DEPTH=4, rx_ready=0, 5 bytes sent -> first 4 bytes are retained in order, overflow=1, and the 5th byte is absent.
REQ-029 SHALL verify: cs raised after 5 bits -> frame_err=1 and no push; the next full byte 0x55 is received intact.
REQ-030 SHALL verify: rst_n pulsed low after 4 bits of a byte -> outputs clear immediately; the next byte 0xA5 is received correctly.

Source files
------------

// File: rtl/lcd_spi_pkg.sv
// Shared constants and types for the LCD SPI receiver.
//   CMD_*        : controller command opcodes recognised by the command tracker
//   *_END_DEF    : default drawing window limits after reset
//   rx_entry_t   : one received byte together with its dc flag (FIFO entry)
package lcd_spi_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic [15:0] COL_END_DEF = 16'd239;
  localparam logic [15:0] ROW_END_DEF = 16'd319;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/lcd_rx_fifo.sv
// Synchronous FIFO for received bytes (9 bits: {dc, byte}).
//   push/wdata : write request; accepted when not full, or when full and popping
//   pop        : read request; ignored when empty
//   rdata      : head entry (combinational from storage)
//   full/empty : occupancy flags
module lcd_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [8:0] wdata,
  input  logic       pop,
  output logic [8:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// SPI (mode 0) receiver for an LCD controller front end.
//   sck/mosi/cs/dc : SPI pins, synchronised to clk internally
//   ena            : receiver enable
//   rx_*           : received-byte FIFO head with valid/ready handshake
//   cur_cmd        : last command byte seen
//   pix_*          : RGB565 pixel stream decoded from RAMWR data, with (x, y) position
//   overflow       : sticky, a byte was dropped on a full FIFO
//   frame_err      : sticky, cs rose in the middle of a byte
import lcd_spi_pkg::*;

module lcd_spi_rx #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        sck,
  input  logic        mosi,
  input  logic        cs,
  input  logic        dc,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        rx_dc,
  output logic [7:0]  cur_cmd,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        overflow,
  output logic        frame_err
);

  // Synchronisers and sck edge detect
  logic [1:0] sck_sync_q, mosi_sync_q, cs_sync_q, dc_sync_q;
  logic       sck_prev_q;
  logic       sck_s, mosi_s, cs_s, dc_s, sck_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      dc_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      cs_sync_q   <= {cs_sync_q[0], cs};
      dc_sync_q   <= {dc_sync_q[0], dc};
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  assign sck_s    = sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign dc_s     = dc_sync_q[1];
  assign sck_rise = sck_s && !sck_prev_q;

  // Shifter
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       bit_stb, byte_stb;
  logic [7:0] byte_val;

  assign bit_stb  = !cs_s && ena && sck_rise;
  assign byte_stb = bit_stb && (bit_cnt_q == 3'd7);
  assign byte_val = {shift_q[6:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      frame_err <= 1'b0;
    end else if (cs_s) begin
      // Bit count can only be nonzero here if cs just rose mid-byte.
      if (bit_cnt_q != 3'd0) frame_err <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (bit_stb) begin
      shift_q   <= byte_val;
      bit_cnt_q <= bit_cnt_q + 3'd1;  // wraps to 0 on the 8th bit
    end
  end

  // Received-byte FIFO
  rx_entry_t wr_entry, rd_entry;
  logic      fifo_full, fifo_empty, fifo_pop;

  assign wr_entry = '{dc: dc_s, data: byte_val};
  assign fifo_pop = rx_valid && rx_ready;

  lcd_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (byte_stb),
    .wdata (wr_entry),
    .pop   (fifo_pop),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign rx_byte  = rd_entry.data;
  assign rx_dc    = rd_entry.dc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (byte_stb && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  // Command tracker, fed straight from the shifter so it never stalls on rx_ready
  logic [7:0]  param_idx_q;
  logic        phase_q;
  logic [7:0]  hi_byte_q;
  logic [15:0] col_start_q, col_end_q, row_start_q, row_end_q;
  logic [15:0] x_q, y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_cmd     <= '0;
      param_idx_q <= '0;
      phase_q     <= 1'b0;
      hi_byte_q   <= '0;
      col_start_q <= '0;
      col_end_q   <= COL_END_DEF;
      row_start_q <= '0;
      row_end_q   <= ROW_END_DEF;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (byte_stb) begin
        if (!dc_s) begin
          cur_cmd     <= byte_val;
          param_idx_q <= '0;
          phase_q     <= 1'b0;
          if (byte_val == CMD_RAMWR) begin
            x_q <= col_start_q;
            y_q <= row_start_q;
          end
        end else begin
          if (param_idx_q != 8'hFF) param_idx_q <= param_idx_q + 8'd1;
          if (cur_cmd == CMD_CASET) begin
            case (param_idx_q)
              8'd0: col_start_q[15:8] <= byte_val;
              8'd1: col_start_q[7:0]  <= byte_val;
              8'd2: col_end_q[15:8]   <= byte_val;
              8'd3: col_end_q[7:0]    <= byte_val;
              default: ;
            endcase
          end else if (cur_cmd == CMD_PASET) begin
            case (param_idx_q)
              8'd0: row_start_q[15:8] <= byte_val;
              8'd1: row_start_q[7:0]  <= byte_val;
              8'd2: row_end_q[15:8]   <= byte_val;
              8'd3: row_end_q[7:0]    <= byte_val;
              default: ;
            endcase
          end else if (cur_cmd == CMD_RAMWR) begin
            if (!phase_q) begin
              hi_byte_q <= byte_val;
              phase_q   <= 1'b1;
            end else begin
              phase_q   <= 1'b0;
              pix_valid <= 1'b1;
              pix_data  <= {hi_byte_q, byte_val};
              pix_x     <= x_q;
              pix_y     <= y_q;
              if (x_q < col_end_q) begin
                x_q <= x_q + 16'd1;
              end else begin
                x_q <= col_start_q;
                y_q <= (y_q >= row_end_q) ? row_start_q : y_q + 16'd1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed self-checking bench for lcd_spi_rx.
module tb_lcd_spi_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs = 1'b1;
  logic        dc = 1'b0;
  logic        rx_ready = 1'b0;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_dc;
  logic [7:0]  cur_cmd;
  logic        pix_valid;
  logic [15:0] pix_data, pix_x, pix_y;
  logic        overflow, frame_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  lcd_spi_rx #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sck       (sck),
    .mosi      (mosi),
    .cs        (cs),
    .dc        (dc),
    .rx_ready  (rx_ready),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rx_dc     (rx_dc),
    .cur_cmd   (cur_cmd),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pixel log: {data, x, y}
  logic [47:0] pix_log [8];
  int          pix_n = 0;

  always @(negedge clk) begin
    if (rst_n && pix_valid === 1'b1) begin
      if (pix_n < 8) pix_log[pix_n] = {pix_data, pix_x, pix_y};
      pix_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    dc = d;
    cs = 1'b0;
    #40;
    send_bits(b, 8);
    #40 cs = 1'b1;
    #80;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] b, input logic d);
    int cyc = 0;
    @(negedge clk);
    while (rx_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (rx_valid !== 1'b1) begin
      check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    end else begin
      check({tag, "_byte"}, {24'd0, rx_byte}, {24'd0, b});
      check({tag, "_dc"}, {31'd0, rx_dc}, {31'd0, d});
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic send_pop(input string tag, input logic [7:0] b, input logic d);
    send_byte(b, d);
    pop_expect(tag, b, d);
  endtask

  int exp_x [5] = '{10, 11, 10, 11, 10};
  int exp_y [5] = '{5, 5, 6, 6, 5};

  initial begin
    // Reset state
    #23;
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_cur_cmd", {24'd0, cur_cmd}, 32'd0);
    check("rst_col_start", {16'd0, dut.col_start_q}, 32'd0);
    check("rst_col_end", {16'd0, dut.col_end_q}, 32'd239);
    check("rst_row_start", {16'd0, dut.row_start_q}, 32'd0);
    check("rst_row_end", {16'd0, dut.row_end_q}, 32'd319);
    rst_n = 1'b1;
    #50;

    // CASET 10..11
    send_pop("caset_cmd", 8'h2A, 1'b0);
    send_pop("caset_p0", 8'h00, 1'b1);
    send_pop("caset_p1", 8'h0A, 1'b1);
    send_pop("caset_p2", 8'h00, 1'b1);
    send_pop("caset_p3", 8'h0B, 1'b1);
    check("caset_col_start", {16'd0, dut.col_start_q}, 32'd10);
    check("caset_col_end", {16'd0, dut.col_end_q}, 32'd11);
    check("caset_cur_cmd", {24'd0, cur_cmd}, 32'h2A);

    // PASET 5..6, RAMWR, five red pixels
    send_pop("paset_cmd", 8'h2B, 1'b0);
    send_pop("paset_p0", 8'h00, 1'b1);
    send_pop("paset_p1", 8'h05, 1'b1);
    send_pop("paset_p2", 8'h00, 1'b1);
    send_pop("paset_p3", 8'h06, 1'b1);
    check("paset_row_start", {16'd0, dut.row_start_q}, 32'd5);
    check("paset_row_end", {16'd0, dut.row_end_q}, 32'd6);
    send_pop("ramwr_cmd", 8'h2C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_pop("px_hi", 8'hF8, 1'b1);
      send_pop("px_lo", 8'h00, 1'b1);
    end
    check("pix_count", pix_n, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("pix%0d_data", i), {16'd0, pix_log[i][47:32]}, 32'hF800);
      check($sformatf("pix%0d_x", i), {16'd0, pix_log[i][31:16]}, exp_x[i]);
      check($sformatf("pix%0d_y", i), {16'd0, pix_log[i][15:0]}, exp_y[i]);
    end
    check("ramwr_cur_cmd", {24'd0, cur_cmd}, 32'h2C);

    // Overflow: 5 bytes into a 4-deep FIFO with no consumer
    send_pop("nop_cmd", 8'h00, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("ovf_before_5th", {31'd0, overflow}, 32'd0);
    send_byte(8'h55, 1'b1);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    pop_expect("ovf0", 8'h11, 1'b1);
    pop_expect("ovf1", 8'h22, 1'b1);
    pop_expect("ovf2", 8'h33, 1'b1);
    pop_expect("ovf3", 8'h44, 1'b1);
    @(negedge clk);
    check("ovf_5th_absent", {31'd0, rx_valid}, 32'd0);
    check("ovf_no_pixels", pix_n, 32'd5);

    // Frame error: cs rises after 5 bits
    dc = 1'b1;
    cs = 1'b0;
    #40;
    send_bits(8'hFF, 5);
    #40 cs = 1'b1;
    #100;
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_no_push", {31'd0, rx_valid}, 32'd0);
    send_pop("ferr_next", 8'h55, 1'b1);

    // Reset mid-byte
    dc = 1'b1;
    cs = 1'b0;
    #40;
    send_bits(8'hF0, 4);
    rst_n = 1'b0;
    #1;
    check("mrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("mrst_overflow", {31'd0, overflow}, 32'd0);
    check("mrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("mrst_cur_cmd", {24'd0, cur_cmd}, 32'd0);
    #30 rst_n = 1'b1;
    #40 cs = 1'b1;
    #80;
    check("mrst_no_partial", {31'd0, rx_valid}, 32'd0);
    send_pop("mrst_next", 8'hA5, 1'b1);
    @(negedge clk);
    check("mrst_empty", {31'd0, rx_valid}, 32'd0);
    check("mrst_frame_err_clear", {31'd0, frame_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
